// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage <-> divider request/response bundle.
//   master (execute stage): drives signed_div, opdata1, opdata2, start, annul;
//                           receives result, ready, busy.
//   slave  (divider):       the mirror image.
//   signed_div : 1 = DIV (two's complement), 0 = DIVU
//   opdata1    : dividend, opdata2 : divisor (both sampled at acceptance)
//   start      : request, held until ready has been consumed
//   annul      : abort the operation in flight
//   result     : {remainder, quotient} = {hi_data, lo_data}
//   ready      : result valid
//   busy       : stall request
interface div_unit_if;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready, busy
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready, busy
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : div_unit_if.slave (operands, start/annul in; result/ready/busy out)
// A nonzero-divisor request takes 32 steps after acceptance; a zero divisor
// completes one edge after acceptance with a zero result. The result is held
// while start stays high and cleared when start drops (or annul rises).
module div_unit (
    input  logic           clk,
    input  logic           reset,
    div_unit_if.slave      bus
);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    // Control state
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    // Datapath state: {partial remainder (33 bits), dividend/quotient (32 bits)}
    logic [64:0] work_q, work_d;
    logic [31:0] dvs_mag_q, dvs_mag_d;
    logic        neg_dvd_q, neg_dvd_d;
    logic        neg_dvs_q, neg_dvs_d;

    logic        neg_dvd_in;
    logic        neg_dvs_in;
    logic [33:0] trial;
    logic [64:0] work_step;

    // Two's-complement negation when neg is set; used both for taking the
    // operand magnitudes and for restoring the result signs.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        logic signed [31:0] s;
        s = $signed(v);
        return neg ? 32'(-s) : v;
    endfunction

    assign neg_dvd_in = bus.signed_div & bus.opdata1[31];
    assign neg_dvs_in = bus.signed_div & bus.opdata2[31];

    // One restoring step. The upper 33 bits after a left shift are
    // work_q[63:31]; work_q[64] is included as a guard bit (always 0 since
    // the partial remainder stays below the divisor), so the 34-bit
    // difference's MSB is the borrow.
    always_comb begin
        trial = work_q[64:31] - {2'b00, dvs_mag_q};
        if (trial[33]) begin
            work_step = {work_q[63:0], 1'b0};
        end else begin
            work_step = {trial[32:0], work_q[30:0], 1'b1};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        work_d    = work_q;
        dvs_mag_d = dvs_mag_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = 64'h0;
                if (bus.start && !bus.annul) begin
                    busy_d = 1'b1;
                    if (bus.opdata2 == 32'h0) begin
                        state_d = BY_ZERO;
                    end else begin
                        state_d   = ON;
                        neg_dvd_d = neg_dvd_in;
                        neg_dvs_d = neg_dvs_in;
                        dvs_mag_d = cond_neg(bus.opdata2, neg_dvs_in);
                        work_d    = {33'b0, cond_neg(bus.opdata1, neg_dvd_in)};
                        cnt_d     = 5'd0;
                    end
                end
            end

            BY_ZERO: begin
                state_d  = END;
                busy_d   = 1'b0;
                ready_d  = 1'b1;
                result_d = 64'h0;
            end

            ON: begin
                // A dropped start is an implicit abort.
                if (bus.annul || !bus.start) begin
                    state_d = FREE;
                    busy_d  = 1'b0;
                    cnt_d   = 5'd0;
                    work_d  = 65'h0;
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = END;
                        busy_d   = 1'b0;
                        ready_d  = 1'b1;
                        // Remainder follows the dividend sign; quotient is
                        // negative when the operand signs differ.
                        result_d = {cond_neg(work_step[63:32], neg_dvd_q),
                                    cond_neg(work_step[31:0], neg_dvd_q ^ neg_dvs_q)};
                    end
                end
            end

            END: begin
                if (!bus.start || bus.annul) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end
            end

            default: begin
                state_d  = FREE;
                busy_d   = 1'b0;
                ready_d  = 1'b0;
                result_d = 64'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= FREE;
            cnt_q    <= 5'd0;
            result_q <= 64'h0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Datapath registers carry no reset: they are always loaded at acceptance
    // before being used.
    always_ff @(posedge clk) begin
        work_q    <= work_d;
        dvs_mag_q <= dvs_mag_d;
        neg_dvd_q <= neg_dvd_d;
        neg_dvs_q <= neg_dvs_d;
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (table vectors, random
// operands against an arithmetic reference, hand-written control sequences).
module tb_div_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div_unit_if bus();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain language-level division, with the one wrap case
    // spelled out and a zero result for a zero divisor.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) return 64'h0;
        if (!sd) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'h0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Full transaction from FREE: accept, perturb operands, wait for ready,
    // hold one extra cycle, then release start.
    task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
        int n;
        bit early_drop;
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        bus.annul      = 1'b0;
        tick();
        check({nm, " busy@accept"}, 64'(bus.busy), 64'd1);
        check({nm, " ready@accept"}, 64'(bus.ready), 64'd0);
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = ~sd;
        n = 0;
        early_drop = 1'b0;
        while (!bus.ready && n < 40) begin
            tick();
            n++;
            if (!bus.ready && !bus.busy) early_drop = 1'b1;
        end
        check({nm, " latency"}, 64'(n), (b == 32'h0) ? 64'd1 : 64'd32);
        check({nm, " busy held"}, 64'(early_drop), 64'd0);
        check({nm, " result"}, bus.result, exp);
        check({nm, " busy@ready"}, 64'(bus.busy), 64'd0);
        tick();
        check({nm, " ready hold"}, 64'(bus.ready), 64'd1);
        check({nm, " result hold"}, bus.result, exp);
        bus.start = 1'b0;
        tick();
        check({nm, " ready clr"}, 64'(bus.ready), 64'd0);
        check({nm, " result clr"}, bus.result, 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        bit          saw_ready;

        tbl[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14}};
        tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}};
        tbl[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000}};
        tbl[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h0,        32'hFFFFFFFF}};
        tbl[5] = '{1'b0, 32'd5,          32'd9,        {32'd5,        32'd0}};
        tbl[6] = '{1'b0, 32'd1234,       32'd0,        64'h0};
        tbl[7] = '{1'b1, 32'h80000000,   32'd0,        64'h0};

        reset          = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'h0;
        bus.opdata2    = 32'h0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        tick();
        tick();
        check("reset result", bus.result, 64'h0);
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].sd, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = $urandom & 32'hFF;
                2: b = 32'hFFFFFFFF - ($urandom & 32'hF);
                default: b = $urandom;
            endcase
            run_op(sd, a, b, model(sd, a, b), $sformatf("rnd%0d", i));
        end

        // annul and start together in FREE: nothing is accepted
        bus.opdata1 = 32'd100;
        bus.opdata2 = 32'd7;
        bus.start   = 1'b1;
        bus.annul   = 1'b1;
        tick();
        tick();
        tick();
        check("annul+start free busy", 64'(bus.busy), 64'd0);
        check("annul+start free ready", 64'(bus.ready), 64'd0);
        bus.start = 1'b0;
        bus.annul = 1'b0;
        tick();

        // annul at step 10, then a fresh request on the following edge
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        bus.start      = 1'b1;
        tick();
        saw_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.ready) saw_ready = 1'b1;
        end
        bus.annul = 1'b1;
        tick();
        check("annul busy", 64'(bus.busy), 64'd0);
        check("annul ready", 64'(bus.ready | saw_ready), 64'd0);
        check("annul result", bus.result, 64'h0);
        bus.annul = 1'b0;
        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "after annul");

        // start dropped mid-operation acts as annul
        bus.opdata1 = 32'd100;
        bus.opdata2 = 32'd7;
        bus.start   = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        bus.start = 1'b0;
        tick();
        check("drop start busy", 64'(bus.busy), 64'd0);
        saw_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.ready || bus.busy) saw_ready = 1'b1;
        end
        check("drop start idle", 64'(saw_ready), 64'd0);

        // reset at step 20
        bus.signed_div = 1'b1;
        bus.opdata1    = 32'hFFFFFFF9;
        bus.opdata2    = 32'd2;
        bus.start      = 1'b1;
        tick();
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b0;
        tick();
        check("rst on busy", 64'(bus.busy), 64'd0);
        check("rst on ready", 64'(bus.ready), 64'd0);
        check("rst on result", bus.result, 64'h0);
        bus.start = 1'b0;
        reset     = 1'b1;
        tick();
        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "after rst");

        // reset in END
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd100;
        bus.opdata2    = 32'd7;
        bus.start      = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) tick();
        check("pre-rst end ready", 64'(bus.ready), 64'd1);
        reset = 1'b0;
        tick();
        check("rst end ready", 64'(bus.ready), 64'd0);
        check("rst end result", bus.result, 64'h0);
        check("rst end busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;
        reset     = 1'b1;
        tick();

        // annul in END behaves like dropping start
        bus.opdata1 = 32'd5;
        bus.opdata2 = 32'd9;
        bus.start   = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) tick();
        check("pre-annul end result", bus.result, {32'd5, 32'd0});
        bus.annul = 1'b1;
        tick();
        check("annul end ready", 64'(bus.ready), 64'd0);
        check("annul end result", bus.result, 64'h0);
        bus.annul = 1'b0;
        bus.start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
